// File: rtl/dcache_pkg.sv
// Shared types and default geometry for the direct-mapped write-back data cache.
package dcache_pkg;

  localparam int unsigned DefLineAddrLen = 3;
  localparam int unsigned DefSetAddrLen  = 3;
  localparam int unsigned DefTagAddrLen  = 30 - DefLineAddrLen - DefSetAddrLen;
  localparam int unsigned DefLineWords   = 1 << DefLineAddrLen;
  localparam int unsigned DefNumSets     = 1 << DefSetAddrLen;

  typedef enum logic [1:0] {IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK} dcacheState_e;

  function automatic int unsigned tagLen(input int unsigned lineLen, input int unsigned setLen);
    return 30 - lineLen - setLen;
  endfunction

endpackage

// File: rtl/dcache_stats.sv
// Saturating hit/miss event counters; only instantiated when DCACHE_STATS_EN is defined.
module dcache_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        hitEv,
  input  logic        missEv,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hitEv && (hit_cnt != '1)) hit_cnt <= hit_cnt + 32'd1;
      if (missEv && (miss_cnt != '1)) miss_cnt <= miss_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with word-serial line refill/evict.
// Define DCACHE_STATS_EN to add the hit_cnt/miss_cnt statistics outputs.
module data_cache
  import dcache_pkg::*;
#(
  parameter int unsigned LINE_ADDR_LEN = DefLineAddrLen,
  parameter int unsigned SET_ADDR_LEN  = DefSetAddrLen
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [3:0]  wr_be,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        miss,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int unsigned TagLen    = tagLen(LINE_ADDR_LEN, SET_ADDR_LEN);
  localparam int unsigned LineWords = 2 ** LINE_ADDR_LEN;
  localparam int unsigned NumSets   = 2 ** SET_ADDR_LEN;

  logic [LINE_ADDR_LEN-1:0] wordIdx;
  logic [SET_ADDR_LEN-1:0]  setIdx;
  logic [TagLen-1:0]        reqTag;
  logic                     unusedAddr;

  assign wordIdx    = addr[LINE_ADDR_LEN+1:2];
  assign setIdx     = addr[LINE_ADDR_LEN+SET_ADDR_LEN+1:LINE_ADDR_LEN+2];
  assign reqTag     = addr[31:LINE_ADDR_LEN+SET_ADDR_LEN+2];
  assign unusedAddr = ^addr[1:0];

  logic [NumSets-1:0] validQ, dirtyQ;
  logic [TagLen-1:0]  tagQ  [NumSets];
  logic [31:0]        dataQ [NumSets][LineWords];

  dcacheState_e             stateQ, stateD;
  logic [LINE_ADDR_LEN-1:0] cntQ, cntD;
  logic [SET_ADDR_LEN-1:0]  victimSetQ;
  logic [TagLen-1:0]        victimTagQ;

  logic req, hit, idleHit, beatDone, lastBeat, missStart, hitDone;

  assign req       = rd_req | wr_req;
  assign hit       = validQ[setIdx] && (tagQ[setIdx] == reqTag);
  assign idleHit   = (stateQ == IDLE) && hit;
  assign miss      = req && !idleHit;
  assign beatDone  = mem_req && mem_ack;
  assign lastBeat  = &cntQ;
  assign missStart = (stateQ == IDLE) && req && !hit;
  assign hitDone   = req && idleHit;

  // State register, beat counter and the victim line latched at miss time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ     <= IDLE;
      cntQ       <= '0;
      victimSetQ <= '0;
      victimTagQ <= '0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      if (missStart) begin
        victimSetQ <= setIdx;
        victimTagQ <= tagQ[setIdx];
      end
    end
  end

  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    unique case (stateQ)
      IDLE: begin
        if (missStart) begin
          cntD   = '0;
          stateD = (validQ[setIdx] && dirtyQ[setIdx]) ? SWAP_OUT : SWAP_IN;
        end
      end
      SWAP_OUT: begin
        if (beatDone) begin
          cntD = cntQ + LINE_ADDR_LEN'(1);
          if (lastBeat) begin
            cntD   = '0;
            stateD = SWAP_IN;
          end
        end
      end
      SWAP_IN: begin
        if (beatDone) begin
          cntD = cntQ + LINE_ADDR_LEN'(1);
          if (lastBeat) stateD = SWAP_IN_OK;
        end
      end
      SWAP_IN_OK: stateD = IDLE;
      default:    stateD = IDLE;
    endcase
  end

  // Memory port is a pure function of state so an async reset drops mem_req at once.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (stateQ)
      SWAP_OUT: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {victimTagQ, victimSetQ, cntQ, 2'b00};
        mem_wdata = dataQ[victimSetQ][cntQ];
      end
      SWAP_IN: begin
        mem_req  = 1'b1;
        mem_addr = {reqTag, victimSetQ, cntQ, 2'b00};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      validQ  <= '0;
      dirtyQ  <= '0;
      rd_data <= '0;
    end else begin
      if (hitDone && wr_req) begin
        dirtyQ[setIdx] <= 1'b1;
      end else if (hitDone) begin
        rd_data <= dataQ[setIdx][wordIdx];
      end
      if (stateQ == SWAP_IN_OK) begin
        validQ[victimSetQ] <= 1'b1;
        dirtyQ[victimSetQ] <= 1'b0;
      end
    end
  end

  // Data words and tags are not reset; validQ guards them.
  always_ff @(posedge clk) begin
    if (hitDone && wr_req) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) dataQ[setIdx][wordIdx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
    if ((stateQ == SWAP_IN) && beatDone) dataQ[victimSetQ][cntQ] <= mem_rdata;
    if (stateQ == SWAP_IN_OK) tagQ[victimSetQ] <= reqTag;
  end

`ifdef DCACHE_STATS_EN
  dcache_stats uStats (
    .clk      (clk),
    .rst      (rst),
    .hitEv    (hitDone),
    .missEv   (missStart),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );
`endif

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: flat architectural memory plus tag model, random traffic.
`timescale 1ns/1ps
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_req = 1'b0, wr_req = 1'b0;
  logic [3:0]  wr_be = 4'h0;
  logic [31:0] addr = '0, wr_data = '0;
  logic [31:0] rd_data;
  logic        miss, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
  int unsigned expHits = 0, expMisses = 0;
`endif

  always #5 clk = ~clk;

  data_cache dut (
    .clk       (clk),
    .rst       (rst),
    .rd_req    (rd_req),
    .wr_req    (wr_req),
    .wr_be     (wr_be),
    .addr      (addr),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .miss      (miss),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: backing memory, the core's view of memory, and per-set tag state.
  typedef struct packed {logic we; logic [31:0] a; logic [31:0] d;} beat_t;
  beat_t       beatQ[$];
  logic [31:0] backing [logic [31:0]];
  logic [31:0] arch    [logic [31:0]];
  bit          mValid [8];
  bit          mDirty [8];
  logic [23:0] mTag   [8];
  int          ackPeriod = 1;
  int          reqAge = 0;
  logic [31:0] expRd = '0;

  function automatic logic [31:0] memInit(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  function automatic logic [31:0] memRd(input logic [31:0] a);
    return backing.exists(a) ? backing[a] : memInit(a);
  endfunction

  function automatic logic [31:0] archRd(input logic [31:0] a);
    return arch.exists(a) ? arch[a] : memInit(a);
  endfunction

  // Memory responder and per-cycle beat checker.
  always @(negedge clk) begin
    if (rst || !mem_req) begin
      mem_ack = 1'b0;
      reqAge  = 0;
    end else begin
      if (beatQ.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected beat: mem_addr %h mem_we %b, no beat expected", mem_addr, mem_we);
      end else begin
        chk("beat mem_we", {31'd0, mem_we}, {31'd0, beatQ[0].we});
        chk("beat mem_addr", mem_addr, beatQ[0].a);
        if (beatQ[0].we) chk("beat mem_wdata", mem_wdata, beatQ[0].d);
      end
      if (reqAge >= ackPeriod - 1) begin
        mem_ack   = 1'b1;
        reqAge    = 0;
        mem_rdata = memRd(mem_addr);
        if (mem_we) backing[mem_addr] = mem_wdata;
        if (beatQ.size() > 0) void'(beatQ.pop_front());
      end else begin
        mem_ack   = 1'b0;
        reqAge++;
        mem_rdata = $urandom;
      end
    end
  end

  // Predicts beats and miss length for one access and updates the tag model.
  function automatic int predict(input bit rd, input bit wr, input logic [31:0] a, input int p);
    logic [2:0]  s;
    logic [23:0] t;
    logic [31:0] va;
    int          nb;
    s = a[7:5];
    t = a[31:8];
    if (!(rd || wr) || (mValid[s] && mTag[s] == t)) return 0;
    nb = 0;
    if (mValid[s] && mDirty[s]) begin
      for (int i = 0; i < 8; i++) begin
        va = {mTag[s], s, 3'(i), 2'b00};
        beatQ.push_back('{we: 1'b1, a: va, d: archRd(va)});
        nb++;
      end
    end
    for (int i = 0; i < 8; i++) begin
      beatQ.push_back('{we: 1'b0, a: {t, s, 3'(i), 2'b00}, d: 32'd0});
      nb++;
    end
    mValid[s] = 1'b1;
    mTag[s]   = t;
    mDirty[s] = 1'b0;
`ifdef DCACHE_STATS_EN
    expMisses++;
`endif
    return 2 + nb * p;
  endfunction

  task automatic drive(input bit rd, input bit wr, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] d);
    @(posedge clk);
    #1;
    rd_req  = rd;
    wr_req  = wr;
    addr    = a | 32'($urandom_range(0, 3));
    wr_be   = be;
    wr_data = d;
  endtask

  task automatic access(input bit rd, input bit wr, input logic [31:0] aIn, input logic [3:0] be,
                        input logic [31:0] d, input int p, output int missCycles);
    logic [31:0] a, w;
    int          expMiss;
    a         = {aIn[31:2], 2'b00};
    expMiss   = predict(rd, wr, a, p);
    ackPeriod = p;
    drive(rd, wr, a, be, d);
    missCycles = 0;
    while (1) begin
      @(negedge clk);
      if (!miss) break;
      missCycles++;
      if (missCycles > 300) begin
        vectors++;
        errors++;
        $display("FAIL miss timeout: addr %h still missing after %0d cycles", a, missCycles);
        break;
      end
    end
    @(posedge clk);
    #1;
    rd_req = 1'b0;
    wr_req = 1'b0;
    if (wr) begin
      w = archRd(a);
      for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
      arch[a] = w;
      mDirty[a[7:5]] = 1'b1;
    end else if (rd) begin
      expRd = archRd(a);
    end
`ifdef DCACHE_STATS_EN
    if (rd || wr) expHits++;
    chk("hit_cnt", hit_cnt, expHits);
    chk("miss_cnt", miss_cnt, expMisses);
`endif
    chk("rd_data", rd_data, expRd);
    chk("miss cycles", missCycles, expMiss);
    chk("beats left", beatQ.size(), 0);
  endtask

  task automatic modelReset();
    beatQ.delete();
    for (int i = 0; i < 8; i++) begin
      mValid[i] = 1'b0;
      mDirty[i] = 1'b0;
    end
    arch  = backing;
    expRd = '0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int mc, dummy;
    repeat (2) @(posedge clk);
    #1;
    chk("reset rd_data", rd_data, 32'h0);
    chk("reset mem_req", {31'd0, mem_req}, 32'h0);
    chk("reset mem_we", {31'd0, mem_we}, 32'h0);
    chk("reset mem_addr", mem_addr, 32'h0);
    chk("reset mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;

    backing[32'h104] = 32'h1122_3344;
    arch[32'h104]    = 32'h1122_3344;

    access(1, 0, 32'h100, 4'h0, 32'h0, 1, mc);
    chk("clean miss length", mc, 10);
    chk("load 0x100 literal", rd_data, 32'hFEFF_0100);

    access(0, 1, 32'h104, 4'b0011, 32'hAAAA_5555, 1, mc);
    chk("store hit no miss", mc, 0);
    access(1, 0, 32'h104, 4'h0, 32'h0, 1, mc);
    chk("merged store literal", rd_data, 32'h1122_5555);

    access(1, 0, 32'h500, 4'h0, 32'h0, 1, mc);
    chk("dirty miss length", mc, 18);

    access(1, 0, 32'h700, 4'h0, 32'h0, 3, mc);
    chk("slow ack miss length", mc, 26);

    // Reset during the 4th refill beat of 0x300.
    ackPeriod = 1;
    dummy = predict(1, 0, 32'h300, 1);
    drive(1, 0, 32'h300, 4'h0, 32'h0);
    repeat (5) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("async reset mem_req", {31'd0, mem_req}, 32'h0);
    chk("async reset mem_addr", mem_addr, 32'h0);
    modelReset();
    rd_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
`ifdef DCACHE_STATS_EN
    expHits   = 0;
    expMisses = 0;
`endif
    access(1, 0, 32'h300, 4'h0, 32'h0, 1, mc);
    chk("refill after reset", mc, 10);

    access(1, 0, 32'h200, 4'h0, 32'h0, 1, mc);
    access(1, 1, 32'h200, 4'hF, 32'hDEAD_BEEF, 1, mc);
    chk("rd+wr no miss", mc, 0);
    chk("rd+wr keeps rd_data", rd_data, 32'hFDFF_0200);
    access(1, 0, 32'h600, 4'h0, 32'h0, 1, mc);
    chk("rd+wr left line dirty", mc, 18);

    for (int n = 0; n < 300; n++) begin
      int          kind;
      logic [31:0] a;
      kind = $urandom_range(0, 9);
      a    = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 5)
           | (32'($urandom_range(0, 7)) << 2);
      access(kind inside {[1:4], 8}, kind inside {[5:8]}, a, 4'($urandom), $urandom,
             $urandom_range(1, 3), mc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
